// File: rtl/ams_pkg.sv
// Shared constants for the PWM DAC channels and the register block that writes their config words.
// The config word carries an 8-bit base duty and a 16-entry, LSB-first dither sequence.
package ams_pkg;

    localparam int unsigned AMS_CCW        = 24;
    localparam int unsigned AMS_CNT_W      = 8;
    localparam int unsigned AMS_DUTY_MSB   = 23;
    localparam int unsigned AMS_DUTY_LSB   = 16;
    localparam int unsigned AMS_DUTY_W     = AMS_DUTY_MSB - AMS_DUTY_LSB + 1;
    localparam int unsigned AMS_DITHER_MSB = 15;
    localparam int unsigned AMS_DITHER_LSB = 0;
    localparam int unsigned AMS_DITHER_W   = AMS_DITHER_MSB - AMS_DITHER_LSB + 1;
    localparam int unsigned AMS_FRAME_LEN  = 16;
    localparam int unsigned AMS_IDX_W      = $clog2(AMS_FRAME_LEN);

    typedef enum logic {
        StIdle,
        StRun
    } ams_state_e;

endpackage

// File: rtl/ams_pwm_dither.sv
// Compare value for one PWM period: base duty plus the dither bit selected by the period index.
// Purely combinational; the 9-bit result spans 0..256 so both rails are reachable.
module ams_pwm_dither
    import ams_pkg::*;
(
    input  logic [AMS_CCW-1:0]   cfg_i,
    input  logic [AMS_IDX_W-1:0] idx_i,
    output logic [AMS_DUTY_W:0]  v_o
);

    logic [AMS_DUTY_W-1:0]   duty;
    logic [AMS_DITHER_W-1:0] dither;

    assign duty   = cfg_i[AMS_DUTY_MSB:AMS_DUTY_LSB];
    assign dither = cfg_i[AMS_DITHER_MSB:AMS_DITHER_LSB];
    assign v_o    = {1'b0, duty} + {{AMS_DUTY_W{1'b0}}, dither[idx_i]};

endmodule

// File: rtl/ams_pwm_dac.sv
// Single-channel dithered PWM DAC: 256-cycle periods grouped into 16-period frames, with the
// configuration word reloaded only at frame boundaries so every frame uses one consistent setting.
module ams_pwm_dac
    import ams_pkg::*;
#(
    parameter int unsigned CCW   = AMS_CCW,
    parameter int unsigned CNT_W = AMS_CNT_W
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           en_i,
    input  logic [CCW-1:0] cfg_i,
    output logic           pwm_o,
    output logic           frame_o,
    output logic [CCW-1:0] cfg_o
);

    ams_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [AMS_IDX_W-1:0] idx_q;
    logic [CCW-1:0]       cfg_q;
    logic                 pwm_q;
    logic                 frame_q;

    logic                 boundary;
    logic [CCW-1:0]       cfg_sel;
    logic [CNT_W:0]       v;

    // IDLE holds cnt/idx at zero, so the first RUN cycle is always a frame boundary.
    always_comb begin
        boundary = (state_q == StIdle) || ((cnt_q == '0) && (idx_q == '0));
        // The boundary period compares against the incoming word, not the stale register.
        cfg_sel  = boundary ? cfg_i : cfg_q;
    end

    ams_pwm_dither u_dither (
        .cfg_i (cfg_sel),
        .idx_i (idx_q),
        .v_o   (v)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            cfg_q   <= '0;
            pwm_q   <= 1'b0;
            frame_q <= 1'b0;
        end else if (!en_i) begin
            // Abort immediately; the partially emitted period is not completed.
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            pwm_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= StRun;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == {CNT_W{1'b1}}) begin
                idx_q <= idx_q + AMS_IDX_W'(1);
            end
            if (boundary) begin
                cfg_q <= cfg_i;
            end
            pwm_q   <= ({1'b0, cnt_q} < v);
            frame_q <= boundary;
        end
    end

    assign pwm_o   = pwm_q;
    assign frame_o = frame_q;
    assign cfg_o   = cfg_q;

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Directed and randomized checks of ams_pwm_dac against a cycle-position reference model.
// The model tracks the position within a 4096-cycle frame and derives the expected outputs.
module tb_ams_pwm_dac;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        en_i;
    logic [23:0] cfg_i;
    logic        pwm_o;
    logic        frame_o;
    logic [23:0] cfg_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: position in frame of the next enabled cycle and the active config.
    int          m_pos = 0;
    logic [23:0] m_cfg = '0;
    logic        e_pwm = 1'b0;
    logic        e_frame = 1'b0;
    int          hi_acc = 0;
    int          fr_acc = 0;

    ams_pwm_dac dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (en_i),
        .cfg_i   (cfg_i),
        .pwm_o   (pwm_o),
        .frame_o (frame_o),
        .cfg_o   (cfg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: predict from the inputs seen at the edge, then sample just after it.
    task automatic step();
        int          per;
        int          c;
        int          v;
        logic [15:0] d;
        if (!rstn_i) begin
            e_pwm   = 1'b0;
            e_frame = 1'b0;
            m_cfg   = '0;
            m_pos   = 0;
        end else if (!en_i) begin
            e_pwm   = 1'b0;
            e_frame = 1'b0;
            m_pos   = 0;
        end else begin
            if (m_pos == 0) m_cfg = cfg_i;
            d       = m_cfg[15:0];
            per     = m_pos / 256;
            c       = m_pos % 256;
            v       = int'(m_cfg[23:16]) + int'(d[4'(per)]);
            e_pwm   = (c < v);
            e_frame = (m_pos == 0);
            m_pos   = (m_pos + 1) % 4096;
        end
        @(posedge clk_i);
        #1;
        chk("pwm", 32'(pwm_o), 32'(e_pwm));
        chk("frame", 32'(frame_o), 32'(e_frame));
        chk("cfg_o", 32'(cfg_o), 32'(m_cfg));
        hi_acc += int'(pwm_o);
        fr_acc += int'(frame_o);
    endtask

    task automatic run_count(input int n, output int h, output int fr);
        hi_acc = 0;
        fr_acc = 0;
        repeat (n) step();
        h  = hi_acc;
        fr = fr_acc;
    endtask

    // Advance until the next enabled edge is a frame boundary.
    task automatic sync_frame();
        int k = 0;
        while (m_pos != 0 && k < 5000) begin
            step();
            k++;
        end
        chk("sync_timeout", 32'(m_pos), 32'd0);
    endtask

    initial begin
        int          h;
        int          fr;
        int          tot;
        int          len;
        logic [23:0] r;

        rstn_i = 1'b0;
        en_i   = 1'b0;
        cfg_i  = 24'h0;
        #1;
        chk("reset_pwm", 32'(pwm_o), 32'd0);
        chk("reset_frame", 32'(frame_o), 32'd0);
        chk("reset_cfg_o", 32'(cfg_o), 32'd0);
        step();
        step();
        rstn_i = 1'b1;
        repeat (3) step();

        // 50% duty, three frames, per-period high time and one frame pulse per frame
        cfg_i = 24'h800000;
        en_i  = 1'b1;
        for (int f = 0; f < 3; f++) begin
            tot = 0;
            for (int p = 0; p < 16; p++) begin
                run_count(256, h, fr);
                chk("s1_period_hi", 32'(h), 32'd128);
                tot += fr;
            end
            chk("s1_frames_per_4096", 32'(tot), 32'd1);
        end
        chk("s1_cfg_o", 32'(cfg_o), 32'h800000);

        // duty 64 with a single dither bit on period 0
        cfg_i = 24'h400001;
        sync_frame();
        tot = 0;
        for (int p = 0; p < 16; p++) begin
            run_count(256, h, fr);
            chk("s2_period_hi", 32'(h), (p == 0) ? 32'd65 : 32'd64);
            tot += h;
        end
        chk("s2_frame_hi", 32'(tot), 32'd1025);

        // rails: constant high across period and frame wraps, then constant low
        cfg_i = 24'hFFFFFF;
        sync_frame();
        run_count(8192, h, fr);
        chk("s3_all_high", 32'(h), 32'd8192);
        cfg_i = 24'h000000;
        sync_frame();
        run_count(4096, h, fr);
        chk("s3_all_low", 32'(h), 32'd0);

        // mid-frame config change is deferred to the next boundary
        cfg_i = 24'h100000;
        sync_frame();
        run_count(1000, h, fr);
        chk("s4_pre_hi", 32'(h), 32'd64);
        cfg_i = 24'hF00000;
        run_count(3096, h, fr);
        chk("s4_rest_hi", 32'(h), 32'd192);
        chk("s4_rest_frames", 32'(fr), 32'd0);
        run_count(256, h, fr);
        chk("s4_new_hi", 32'(h), 32'd240);
        chk("s4_new_frame", 32'(fr), 32'd1);
        chk("s4_cfg_o", 32'(cfg_o), 32'hF00000);

        // abort at cnt=50, idx=7, then restart with a fresh word
        cfg_i = 24'($urandom);
        sync_frame();
        run_count(7 * 256 + 50, h, fr);
        en_i = 1'b0;
        step();
        chk("s5_abort_pwm", 32'(pwm_o), 32'd0);
        r     = 24'($urandom);
        cfg_i = r;
        repeat (9) step();
        en_i = 1'b1;
        step();
        chk("s5_restart_frame", 32'(frame_o), 32'd1);
        chk("s5_restart_cfg_o", 32'(cfg_o), 32'(r));

        // random configs with sporadic enable drops
        for (int it = 0; it < 4; it++) begin
            cfg_i = 24'($urandom);
            len   = int'($urandom_range(300, 3000));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 199) == 0) en_i = ~en_i;
                if ($urandom_range(0, 499) == 0) cfg_i = 24'($urandom);
                step();
            end
        end
        en_i = 1'b1;

        // asynchronous reset between edges while the output is high
        cfg_i = 24'h800000;
        sync_frame();
        repeat (10) step();
        chk("s6_pre_pwm", 32'(pwm_o), 32'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        m_pos = 0;
        m_cfg = '0;
        chk("s6_async_pwm", 32'(pwm_o), 32'd0);
        chk("s6_async_frame", 32'(frame_o), 32'd0);
        chk("s6_async_cfg_o", 32'(cfg_o), 32'd0);
        step();
        step();
        rstn_i = 1'b1;
        cfg_i  = 24'h400001;
        step();
        chk("s6_first_frame", 32'(frame_o), 32'd1);
        chk("s6_first_cfg_o", 32'(cfg_o), 32'h400001);
        run_count(255, h, fr);
        chk("s6_first_period_hi", 32'(h + 1), 32'd65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
